// File: rtl/imem_boot_loader_pkg.sv
// Shared constants, FSM state encoding and helpers for the imem byte-stream boot loader.
// Imported by the interface, the loader and its testbench.
package imem_boot_loader_pkg;

  localparam int         DEF_IMEM_BYTES = 128;
  localparam int         DEF_ADDR_W     = $clog2(DEF_IMEM_BYTES);
  localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;

  // Byte counter and frame length are kept at the full 16-bit LEN field width.
  localparam int CNT_W = 16;

  // Frame layout: SYNC, LEN_LO, LEN_HI, LEN data bytes, CHK.
  localparam int HDR_BYTES = 3;
  localparam int TRL_BYTES = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } boot_state_e;

  // An image fits when its length does not exceed the memory capacity.
  function automatic logic len_fits(input logic [CNT_W-1:0] len, input int cap);
    return len <= CNT_W'(cap);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, imem write port and cpu control bundle of the boot loader.
// master = byte source / system side, slave = the loader itself.
interface imem_boot_loader_if #(
  parameter int ADDR_W = imem_boot_loader_pkg::DEF_ADDR_W
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error
  );

endinterface

// File: rtl/imem_boot_loader.sv
// Frame parser that streams a checksummed image into imem and holds the cpu in reset
// until a complete, valid image has been written.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int         IMEM_BYTES = DEF_IMEM_BYTES,
  parameter int         ADDR_W     = DEF_ADDR_W,
  parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);

  boot_state_e       r_state;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_xor;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [7:0]        r_imem_wdata;
  logic              r_cpu_rst;
  logic              r_done;
  logic              r_error;

  boot_state_e       w_state_nxt;
  logic [CNT_W-1:0]  w_len_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [7:0]        w_xor_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [7:0]        w_wdata_nxt;
  logic              w_cpu_rst_nxt;
  logic              w_done_nxt;
  logic              w_error_nxt;

  logic              w_in_ready;
  logic              w_accept;
  logic [CNT_W-1:0]  w_len_full;
  logic [CNT_W-1:0]  w_count_inc;

  // Readiness depends on state only, so a source may never see it combinationally
  // follow its own in_valid.
  assign w_in_ready  = (r_state != S_DONE);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_len_full  = {bus.in_data, r_len[7:0]};
  assign w_count_inc = r_count + CNT_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_count_nxt = r_count;
    w_xor_nxt   = r_xor;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_imem_addr;
    w_wdata_nxt = r_imem_wdata;

    if (w_accept) begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (bus.in_data == SYNC_BYTE) begin
            w_state_nxt = S_LEN_LO;
            w_count_nxt = '0;
            w_xor_nxt   = '0;
          end
        end
        S_LEN_LO: begin
          w_len_nxt   = {8'h00, bus.in_data};
          w_state_nxt = S_LEN_HI;
        end
        S_LEN_HI: begin
          w_len_nxt = w_len_full;
          if (!len_fits(w_len_full, IMEM_BYTES)) begin
            w_state_nxt = S_ERR;
          end else if (w_len_full == '0) begin
            w_state_nxt = S_CHK;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_count[ADDR_W-1:0];
          w_wdata_nxt = bus.in_data;
          w_count_nxt = w_count_inc;
          w_xor_nxt   = r_xor ^ bus.in_data;
          if (w_count_inc == r_len) begin
            w_state_nxt = S_CHK;
          end
        end
        S_CHK: begin
          w_state_nxt = (bus.in_data == r_xor) ? S_DONE : S_ERR;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end

    // Status flags are decoded from the next state and then registered, so the
    // cpu reset line never glitches on a multi-bit state change.
    w_cpu_rst_nxt = (w_state_nxt != S_DONE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_error_nxt   = (w_state_nxt == S_ERR);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_count      <= '0;
      r_xor        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_rst    <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_len        <= w_len_nxt;
      r_count      <= w_count_nxt;
      r_xor        <= w_xor_nxt;
      r_imem_we    <= w_we_nxt;
      r_imem_addr  <= w_addr_nxt;
      r_imem_wdata <= w_wdata_nxt;
      r_cpu_rst    <= w_cpu_rst_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.cpu_rst    = r_cpu_rst;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule
